// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with optional parity, per-entry
// framing/parity error tags, sticky overrun and a first-word-fall-through
// receive FIFO with a level-threshold interrupt.
module uart_rx_fifo #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            RSTn,
  input  logic                            tick,
  input  logic                            RXD,
  input  logic                            par_en,
  input  logic                            par_odd,
  input  logic [$clog2(FIFO_DEPTH):0]     irq_level,
  input  logic                            rd,
  input  logic                            ovr_clr,
  output logic                            rx_valid,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            rx_frame_err,
  output logic                            rx_par_err,
  output logic                            overrun,
  output logic [$clog2(FIFO_DEPTH):0]     count,
  output logic                            interrupt,
  output logic                            busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int WW = DATA_BITS + 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Mid start bit is half a bit in; every later sample is a full bit later.
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  logic [1:0]           sync_q;
  logic                 rxd_s;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 push_q, push_d;
  logic [WW-1:0]        pword_q, pword_d;

  logic [CW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        count_s, count_d;
  logic [WW-1:0]        mem_q [FIFO_DEPTH];
  logic [WW-1:0]        head_q, head_d;
  logic                 overrun_q, overrun_d;
  logic                 pop_s, full_s, wr_en_s, ovr_set_s;

  // Two-flop synchronizer for the asynchronous serial line, idle high.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RXD};
    end
  end

  assign rxd_s = sync_q[1];

  // Receiver FSM: start qualification, data/parity/stop sampling, push request.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    push_d  = 1'b0;
    pword_d = pword_q;
    case (state_q)
      ST_IDLE: begin
        if (!rxd_s) begin
          state_d = ST_START;
          tcnt_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tcnt_q == T_MID) begin
            tcnt_d = '0;
            if (!rxd_s) begin
              state_d = ST_DATA;
              bcnt_d  = '0;
              perr_d  = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            if (bcnt_q == B_LAST) begin
              state_d = par_en ? ST_PARITY : ST_STOP;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            perr_d  = ((^shift_q) ^ rxd_s) != par_odd;
            state_d = ST_STOP;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            push_d  = 1'b1;
            pword_d = {~rxd_s, perr_q & par_en, shift_q};
            state_d = ST_IDLE;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tcnt_d  = '0;
      end
    endcase
  end

  // Receiver state registers; a reset mid-frame abandons the partial frame.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      push_q  <= 1'b0;
      pword_q <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      push_q  <= push_d;
      pword_q <= pword_d;
    end
  end

  assign count_s   = wr_q - rd_q;
  assign pop_s     = rd && (count_s != '0);
  assign full_s    = (count_s == C_FULL);
  // A full FIFO still accepts the push when a pop frees a slot in the same cycle.
  assign wr_en_s   = push_q && (!full_s || pop_s);
  assign ovr_set_s = push_q && full_s && !pop_s;

  // FIFO pointer, head and sticky overrun next-state; set wins over clear.
  always_comb begin
    wr_d      = wr_q + (wr_en_s ? CW'(1) : CW'(0));
    rd_d      = rd_q + (pop_s ? CW'(1) : CW'(0));
    count_d   = wr_d - rd_d;
    head_d    = '0;
    overrun_d = overrun_q;
    if (count_d == '0) begin
      head_d = '0;
    end else if (wr_en_s && (rd_d == wr_q)) begin
      head_d = pword_q;
    end else begin
      head_d = mem_q[rd_d[AW-1:0]];
    end
    if (ovr_set_s) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // FIFO control registers and the registered fall-through head entry.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_q      <= '0;
      rd_q      <= '0;
      head_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      head_q    <= head_d;
      overrun_q <= overrun_d;
    end
  end

  // FIFO storage; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_q[AW-1:0]] <= pword_q;
    end
  end

  assign count        = count_s;
  assign rx_valid     = (count_s != '0);
  assign rx_data      = head_q[DATA_BITS-1:0];
  assign rx_par_err   = head_q[DATA_BITS];
  assign rx_frame_err = head_q[DATA_BITS+1];
  assign overrun      = overrun_q;
  assign interrupt    = (count_s >= irq_level) || overrun_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
